// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback arbiter (ALU vs load) onto the single register-file write port, plus pending-write scoreboard.
// Write port is registered (1 cycle after grant); requesters see combinational ready, decode sees combinational issue_ready.
module regfile_wb_scheduler #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            issue_valid,
  input  logic            issue_has_rd,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  output logic            issue_ready,

  input  logic            alu_wb_valid,
  input  logic [AW-1:0]   alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,

  input  logic            mem_wb_valid,
  input  logic [AW-1:0]   mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            mem_wb_ready,

  output logic            rf_we,
  output logic [AW-1:0]   rf_rd_addr,
  output logic [XLEN-1:0] rf_write_data,
  output logic [NREG-1:0] pending
);

  logic            prio;
  logic            alu_grant;
  logic            mem_grant;
  logic            issue_fire;
  logic [NREG-1:0] pending_nxt;

  // prio = 0 favours the ALU when both requesters are valid
  always_comb begin
    alu_grant = alu_wb_valid & (~mem_wb_valid | ~prio);
    mem_grant = mem_wb_valid & (~alu_wb_valid | prio);
  end

  assign alu_wb_ready = alu_grant;
  assign mem_wb_ready = mem_grant;

  assign issue_ready = ~(pending[issue_rs1] | pending[issue_rs2] |
                         (issue_has_rd & pending[issue_rd]));
  assign issue_fire  = issue_valid & issue_ready;

  // Clear from the staged write first so a same-cycle issue to that rd wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_we) begin
      pending_nxt[rf_rd_addr] = 1'b0;
    end
    if (issue_fire && issue_has_rd && (issue_rd != '0)) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending       <= '0;
      prio          <= 1'b0;
      rf_we         <= 1'b0;
      rf_rd_addr    <= '0;
      rf_write_data <= '0;
    end else begin
      pending <= pending_nxt;
      if (alu_grant) begin
        prio          <= 1'b1;
        rf_we         <= (alu_wb_rd != '0);
        rf_rd_addr    <= alu_wb_rd;
        rf_write_data <= alu_wb_data;
      end else if (mem_grant) begin
        prio          <= 1'b0;
        rf_we         <= (mem_wb_rd != '0);
        rf_rd_addr    <= mem_wb_rd;
        rf_write_data <= mem_wb_data;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler and hazard scoreboard for the 32 x 64-bit register file. It arbitrates two writeback requesters (ALU and load unit) onto the register file's single write port using round-robin priority and a registered write stage. It tracks in-flight destination registers in a pending scoreboard, and stalls issue of any instruction whose rs1, rs2 or rd is still awaiting writeback. It sits between the execute/memory stages and the register file's write_data / rd_addr / reg_write_enable inputs.

## Interface
- XLEN, 64, data width
- NREG, 32, register count (address width = 5)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- issue_valid  in  1  decode presents an instruction
- issue_has_rd  in  1  instruction writes a register
- issue_rd / issue_rs1 / issue_rs2  in  5 each  destination and source addresses
- issue_ready  out  1  instruction may issue this cycle
- alu_wb_valid / alu_wb_rd / alu_wb_data  in  1/5/XLEN  ALU writeback request
- alu_wb_ready  out  1  ALU request accepted this cycle
- mem_wb_valid / mem_wb_rd / mem_wb_data  in  1/5/XLEN  load writeback request
- mem_wb_ready  out  1  load request accepted this cycle
- rf_we / rf_rd_addr / rf_write_data  out  1/5/XLEN  register file write port, registered
- pending  out  NREG  scoreboard, bit i = register i awaiting writeback

## Operation
- Scoreboard: pending[0] is constant 0.
  - Issue handshake (issue_valid && issue_ready) with issue_has_rd and issue_rd != 0 sets pending[issue_rd].
  - A cycle with rf_we=1 clears pending[rf_rd_addr].
  - Set and clear of the same bit in one cycle: set wins.
- issue_ready is combinational: !(pending[issue_rs1] | pending[issue_rs2] | (issue_has_rd & pending[issue_rd])). x0 never stalls.
- Arbitration uses a 1-bit priority register prio (0 = ALU favoured).
  - One requester valid: that requester is granted.
  - Both valid: the requester selected by prio is granted; the other is held with ready=0 and must keep valid/rd/data stable.
  - Any grant sets prio to favour the non-granted source (ALU grant -> prio=1, MEM grant -> prio=0).
- Ready is combinational from valid and prio; at most one ready is high per cycle.
- Write stage: on a grant, the next edge loads rf_rd_addr and rf_write_data from the granted source, and sets rf_we = 1 if rd != 0, else 0.
  - rd = 0 requests are still accepted (ready=1) but produce no write.
  - No grant -> rf_we=0 next cycle; addr/data hold their last values.
- A writeback to a non-pending register is performed normally; the scoreboard is unaffected.
- The register file has no backpressure, so a grant is issued every cycle any request is valid.

## Timing
- Reset (asynchronous assert, synchronous release): pending=0, prio=0, rf_we=0, rf_rd_addr=0, rf_write_data=0.
- Reset mid-operation discards any staged write (rf_we forced 0) and clears all pending bits.
- Issue at edge T: pending[rd]=1 visible after T.
- Writeback accepted at edge T: rf_we=1 during cycle T..T+1. The register file captures at edge T+1, and pending[rd] clears at edge T+1.
- A dependent instruction stalled on that rd sees issue_ready=1 in the cycle after edge T+1 and reads the new value combinationally from the register file.
- Throughput: one writeback per cycle total. Under sustained dual requests, grants alternate ALU, MEM, ALU, ...
- Write-to-dependent-issue latency: 2 cycles from writeback acceptance.

## Test plan
- Reset: assert reset=0 mid-run with pending=0x0000_00F0 and a staged write -> pending=0, rf_we=0, rf_rd_addr=0, rf_write_data=0 immediately. After release, the first grant goes to the ALU when both are valid.
- Single ALU writeback: issue rd=5 -> pending[5]=1. alu_wb rd=5 data=0x1234 -> alu_wb_ready=1; next cycle rf_we=1, rf_rd_addr=5, rf_write_data=0x1234; the cycle after, pending[5]=0.
- Hazard stall: pending[7]=1; issue rs1=7 -> issue_ready=0 until the cycle after rf_we=1 with rf_rd_addr=7, then issue_ready=1. issue rs1=0 with pending[0]=0 is never stalled.
- Contention: ALU and MEM both valid for 4 cycles (rd=1..4 / rd=9..12) -> grants ALU, MEM, ALU, MEM. Held requests keep data stable, and rf writes appear in grant order.
- x0 handling: mem_wb rd=0 data=0xFFFF -> mem_wb_ready=1, rf_we stays 0. Issue with issue_has_rd and rd=0 leaves pending unchanged.
- Back-to-back reuse: writeback clearing pending[3] and a new issue with rd=3 in the same cycle (issue_has_rd=0 path for the stalled one, then a forced scoreboard set) -> pending[3]=1 afterwards (set wins).
